mxu_drain: RTL and testbench

- Result-drain stage directly downstream of the mxu.
- On a drain command it waits for the mxu result-ready indication and snapshots all 16 result rows, int8 or int16, into a local buffer.
- It then streams the rows to the LSU write-back port, one 128-bit beat per valid/ready handshake, with per-beat address generation.
- The mxu is freed for the next tile as soon as the snapshot is taken.

---
 rtl/mxu_drain.sv | 138 +++++++++++++
 tb/tb_mxu_drain.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mxu_drain.sv
// Result-drain stage behind the mxu: snapshots all result rows on data-ready,
// frees the mxu, then streams the rows as DW-bit write-back beats with per-beat addresses.
module mxu_drain #(
    parameter int ROWS = 16,
    parameter int DW   = 128,
    parameter int AW   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   drn_start,
    input  logic [AW-1:0]          drn_base_addr,
    input  logic [AW-1:0]          drn_stride,
    input  logic                   drn_int16,
    input  logic                   mxu_lsu_data_rdy,
    input  logic [ROWS*DW-1:0]     mxu_int8_data,
    input  logic [ROWS*2*DW-1:0]   mxu_int16_data,
    output logic                   wb_vld,
    input  logic                   wb_rdy,
    output logic [AW-1:0]          wb_addr,
    output logic [DW-1:0]          wb_data,
    output logic                   wb_last,
    output logic                   drn_busy,
    output logic                   drn_done
);

    localparam int RW = $clog2(ROWS);
    localparam int BW = RW + 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
    localparam logic [AW-1:0] HALF_OFS = AW'(DW / 8);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_SEND,
        S_DONE
    } state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic [AW-1:0]             r_base;
    logic [AW-1:0]             r_stride;
    logic [AW-1:0]             r_row_addr;
    logic                      r_int16;
    logic                      r_half;
    logic [RW-1:0]             r_row;
    logic [2*ROWS-1:0][DW-1:0] r_buf;
    logic [2*ROWS-1:0][DW-1:0] w_snap;
    logic [BW-1:0]             w_beat;
    logic                      w_fire;
    logic                      w_last;

    // Every row owns two DW slots; int8 rows use only the low slot.
    always_comb begin
        w_snap = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (r_int16) begin
                w_snap[2*r]   = mxu_int16_data[r*2*DW +: DW];
                w_snap[2*r+1] = mxu_int16_data[r*2*DW+DW +: DW];
            end else begin
                w_snap[2*r]   = mxu_int8_data[r*DW +: DW];
            end
        end
    end

    assign w_beat   = {r_row, r_half};
    assign w_fire   = wb_vld && wb_rdy;
    assign w_last   = (r_row == LAST_ROW) && (!r_int16 || r_half);

    assign wb_vld   = (r_state == S_SEND);
    assign wb_last  = wb_vld && w_last;
    assign wb_addr  = wb_vld ? (r_row_addr + (r_half ? HALF_OFS : '0)) : '0;
    assign wb_data  = wb_vld ? r_buf[w_beat] : '0;
    assign drn_busy = (r_state != S_IDLE);
    assign drn_done = (r_state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (drn_start)             w_next = S_WAIT;
            S_WAIT: if (mxu_lsu_data_rdy)      w_next = S_SEND;
            S_SEND: if (w_fire && w_last)      w_next = S_DONE;
            S_DONE:                            w_next = S_IDLE;
            default:                           w_next = S_IDLE;
        endcase
    end

    // Row address is accumulated by stride instead of multiplied per beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base     <= '0;
            r_stride   <= '0;
            r_int16    <= 1'b0;
            r_row      <= '0;
            r_half     <= 1'b0;
            r_row_addr <= '0;
            r_buf      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (drn_start) begin
                        r_base   <= drn_base_addr;
                        r_stride <= drn_stride;
                        r_int16  <= drn_int16;
                    end
                end
                S_WAIT: begin
                    if (mxu_lsu_data_rdy) begin
                        r_buf      <= w_snap;
                        r_row      <= '0;
                        r_half     <= 1'b0;
                        r_row_addr <= r_base;
                    end
                end
                S_SEND: begin
                    if (w_fire) begin
                        if (r_int16 && !r_half) begin
                            r_half <= 1'b1;
                        end else begin
                            r_half     <= 1'b0;
                            r_row      <= r_row + 1'b1;
                            r_row_addr <= r_row_addr + r_stride;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mxu_drain.sv
// Randomized bench for mxu_drain; expected beats come from a plain arithmetic model.
module tb_mxu_drain;

    localparam int ROWS = 16;
    localparam int DW   = 128;
    localparam int AW   = 16;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 drn_start;
    logic [AW-1:0]        drn_base_addr;
    logic [AW-1:0]        drn_stride;
    logic                 drn_int16;
    logic                 mxu_lsu_data_rdy;
    logic [ROWS*DW-1:0]   mxu_int8_data;
    logic [ROWS*2*DW-1:0] mxu_int16_data;
    logic                 wb_vld;
    logic                 wb_rdy;
    logic [AW-1:0]        wb_addr;
    logic [DW-1:0]        wb_data;
    logic                 wb_last;
    logic                 drn_busy;
    logic                 drn_done;

    mxu_drain #(.ROWS(ROWS), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .drn_start(drn_start),
        .drn_base_addr(drn_base_addr), .drn_stride(drn_stride), .drn_int16(drn_int16),
        .mxu_lsu_data_rdy(mxu_lsu_data_rdy), .mxu_int8_data(mxu_int8_data),
        .mxu_int16_data(mxu_int16_data), .wb_vld(wb_vld), .wb_rdy(wb_rdy),
        .wb_addr(wb_addr), .wb_data(wb_data), .wb_last(wb_last),
        .drn_busy(drn_busy), .drn_done(drn_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0]   m8  [ROWS];
    logic [2*DW-1:0] m16 [ROWS];

    logic [AW-1:0] oa[$];
    logic [DW-1:0] od[$];
    logic          ol[$];
    int stall_err, vld_drop, wait_err, lat, send_cyc;
    bit timeout, done_hit, done_busy, done_after, busy_after;

    function automatic logic [AW-1:0] m_addr(int k, logic [AW-1:0] b, logic [AW-1:0] s, bit i16);
        int row  = i16 ? k / 2 : k;
        int half = i16 ? k % 2 : 0;
        return AW'(b + row * s + half * (DW / 8));
    endfunction

    function automatic logic [DW-1:0] m_data(int k, bit i16);
        if (!i16) return m8[k];
        return (k % 2 == 1) ? m16[k/2][2*DW-1:DW] : m16[k/2][DW-1:0];
    endfunction

    task automatic apply_rows();
        for (int r = 0; r < ROWS; r++) begin
            mxu_int8_data[r*DW +: DW]     = m8[r];
            mxu_int16_data[r*2*DW +: 2*DW] = m16[r];
        end
    endtask

    task automatic fill_random();
        for (int r = 0; r < ROWS; r++) begin
            m8[r]  = {$urandom, $urandom, $urandom, $urandom};
            m16[r] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        end
        apply_rows();
    endtask

    task automatic fill_pattern();
        for (int r = 0; r < ROWS; r++) begin
            m8[r]  = {16{8'(r + 1)}};
            m16[r] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        end
        apply_rows();
    endtask

    // Drives one drain and records accepted beats plus protocol observations.
    task automatic drain_run(input logic [AW-1:0] base, input logic [AW-1:0] stride, input bit i16,
                             input int bp_pct, input int wait_cyc, input bit glitch,
                             input bit scramble, input int reset_at);
        int nbeats = i16 ? 2 * ROWS : ROWS;
        int cyc = 0;
        bit pv_stall = 0;
        bit rd;
        logic [AW-1:0] pa = '0;
        logic [DW-1:0] pd = '0;
        logic          pl = 1'b0;
        oa.delete(); od.delete(); ol.delete();
        stall_err = 0; vld_drop = 0; wait_err = 0; lat = -1; send_cyc = 0; timeout = 0;
        @(negedge clk);
        drn_base_addr = base; drn_stride = stride; drn_int16 = i16; drn_start = 1'b1;
        @(negedge clk);
        drn_start = 1'b0;
        drn_base_addr = AW'($urandom); drn_stride = AW'($urandom); drn_int16 = ~i16;
        for (int i = 0; i < wait_cyc; i++) begin
            if (wb_vld !== 1'b0 || drn_busy !== 1'b1) wait_err++;
            @(negedge clk);
        end
        if (wb_vld !== 1'b0 || drn_busy !== 1'b1) wait_err++;
        mxu_lsu_data_rdy = 1'b1;
        @(negedge clk);
        mxu_lsu_data_rdy = 1'b0;
        if (scramble) begin
            mxu_int8_data  = ~mxu_int8_data;
            mxu_int16_data = ~mxu_int16_data;
        end
        while (oa.size() < nbeats && cyc < 400) begin
            if (reset_at >= 0 && oa.size() == reset_at) begin
                rst_n = 1'b0;
                wb_rdy = 1'b0;
                return;
            end
            if (wb_vld === 1'b1 && lat < 0) lat = cyc;
            if (lat >= 0) begin
                send_cyc++;
                if (wb_vld !== 1'b1) vld_drop++;
            end
            if (pv_stall && (wb_addr !== pa || wb_data !== pd || wb_last !== pl)) stall_err++;
            rd = ($urandom_range(99) >= bp_pct);
            wb_rdy = rd;
            if (glitch && oa.size() == 5) begin
                drn_start = 1'b1; drn_base_addr = 16'h7000; drn_stride = 16'h0100;
            end else begin
                drn_start = 1'b0;
            end
            if (wb_vld === 1'b1) begin
                pa = wb_addr; pd = wb_data; pl = wb_last; pv_stall = !rd;
                if (rd) begin
                    oa.push_back(wb_addr); od.push_back(wb_data); ol.push_back(wb_last);
                end
            end else begin
                pv_stall = 0;
            end
            @(negedge clk);
            cyc++;
        end
        drn_start = 1'b0;
        wb_rdy = 1'b0;
        if (cyc >= 400) timeout = 1;
        done_hit = drn_done; done_busy = drn_busy;
        drn_start = 1'b1;
        drn_base_addr = 16'h5555;
        @(negedge clk);
        drn_start = 1'b0;
        done_after = drn_done; busy_after = drn_busy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({wb_vld, wb_last, drn_busy, drn_done, wb_addr, wb_data} !== '0) begin
            bad++;
            $display("FAIL reset_outputs vld=%b last=%b busy=%b done=%b addr=%h data=%h required all 0",
                     wb_vld, wb_last, drn_busy, drn_done, wb_addr, wb_data);
        end
        rst_n = 1'b1;
        mxu_lsu_data_rdy = 1'b1;
        repeat (2) @(negedge clk);
        mxu_lsu_data_rdy = 1'b0;
        total++;
        if (drn_busy !== 1'b0 || wb_vld !== 1'b0) begin
            bad++;
            $display("FAIL idle_ignores_rdy busy=%b vld=%b required 0 0", drn_busy, wb_vld);
        end
    endtask

    task automatic test_int8();
        logic [AW-1:0] b = 16'h1000;
        logic [AW-1:0] s = 16'h0010;
        fill_pattern();
        drain_run(b, s, 1'b0, 0, 3, 1'b0, 1'b0, -1);
        total++;
        if (oa.size() !== ROWS) begin bad++; $display("FAIL int8_count got=%0d want=%0d", oa.size(), ROWS); end
        for (int k = 0; k < oa.size() && k < ROWS; k++) begin
            total++;
            if (oa[k] !== m_addr(k, b, s, 0) || od[k] !== m_data(k, 0) || ol[k] !== (k == ROWS - 1)) begin
                bad++;
                $display("FAIL int8_beat%0d addr=%h want=%h data=%h want=%h last=%b", k, oa[k],
                         m_addr(k, b, s, 0), od[k], m_data(k, 0), ol[k]);
            end
        end
        total++;
        if ({timeout, wait_err != 0, vld_drop != 0, done_hit, done_busy, done_after, busy_after} !== 7'b0001100) begin
            bad++;
            $display("FAIL int8_flags to=%b wait=%0d drop=%0d done=%b busy=%b done_after=%b busy_after=%b",
                     timeout, wait_err, vld_drop, done_hit, done_busy, done_after, busy_after);
        end
        total++;
        if (lat !== 0 || send_cyc !== ROWS) begin
            bad++; $display("FAIL int8_timing lat=%0d send=%0d want 0 %0d", lat, send_cyc, ROWS);
        end
    endtask

    task automatic test_int16();
        logic [AW-1:0] b = 16'h2000;
        logic [AW-1:0] s = 16'h0040;
        int n = 2 * ROWS;
        fill_random();
        drain_run(b, s, 1'b1, 0, 1, 1'b0, 1'b0, -1);
        total++;
        if (oa.size() !== n) begin bad++; $display("FAIL int16_count got=%0d want=%0d", oa.size(), n); end
        for (int k = 0; k < oa.size() && k < n; k++) begin
            total++;
            if (oa[k] !== m_addr(k, b, s, 1) || od[k] !== m_data(k, 1) || ol[k] !== (k == n - 1)) begin
                bad++;
                $display("FAIL int16_beat%0d addr=%h want=%h data=%h want=%h last=%b", k, oa[k],
                         m_addr(k, b, s, 1), od[k], m_data(k, 1), ol[k]);
            end
        end
        total++;
        if (oa.size() == n && oa[n-1] !== 16'h23D0) begin
            bad++; $display("FAIL int16_final_addr got=%h want=23d0", oa[n-1]);
        end
        total++;
        if ({timeout, vld_drop != 0, done_hit, done_busy, done_after, busy_after} !== 6'b001100 ||
            lat !== 0 || send_cyc !== n) begin
            bad++;
            $display("FAIL int16_flags to=%b drop=%0d done=%b busy=%b after=%b/%b lat=%0d send=%0d",
                     timeout, vld_drop, done_hit, done_busy, done_after, busy_after, lat, send_cyc);
        end
    endtask

    task automatic test_backpressure();
        for (int t = 0; t < 4; t++) begin
            bit i16 = t[0];
            logic [AW-1:0] b = AW'($urandom);
            logic [AW-1:0] s = AW'($urandom_range(16'h0200));
            int n = i16 ? 2 * ROWS : ROWS;
            fill_random();
            drain_run(b, s, i16, 50, $urandom_range(4), 1'b0, 1'b0, -1);
            total++;
            if (oa.size() !== n) begin bad++; $display("FAIL bp%0d_count got=%0d want=%0d", t, oa.size(), n); end
            for (int k = 0; k < oa.size() && k < n; k++) begin
                total++;
                if (oa[k] !== m_addr(k, b, s, i16) || od[k] !== m_data(k, i16) || ol[k] !== (k == n - 1)) begin
                    bad++;
                    $display("FAIL bp%0d_beat%0d addr=%h want=%h data=%h want=%h", t, k, oa[k],
                             m_addr(k, b, s, i16), od[k], m_data(k, i16));
                end
            end
            total++;
            if ({timeout, stall_err != 0, vld_drop != 0, done_hit, done_after} !== 5'b00010) begin
                bad++;
                $display("FAIL bp%0d_flags to=%b stall=%0d drop=%0d done=%b done_after=%b",
                         t, timeout, stall_err, vld_drop, done_hit, done_after);
            end
        end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] b = 16'hFFF0;
        logic [AW-1:0] s = 16'h0010;
        fill_random();
        drain_run(b, s, 1'b0, 25, 0, 1'b0, 1'b0, -1);
        total++;
        if (oa.size() !== ROWS) begin bad++; $display("FAIL wrap_count got=%0d want=%0d", oa.size(), ROWS); end
        for (int k = 0; k < oa.size() && k < ROWS; k++) begin
            total++;
            if (oa[k] !== m_addr(k, b, s, 0) || od[k] !== m_data(k, 0)) begin
                bad++;
                $display("FAIL wrap_beat%0d addr=%h want=%h", k, oa[k], m_addr(k, b, s, 0));
            end
        end
        total++;
        if (oa.size() > 1 && oa[1] !== 16'h0000) begin
            bad++; $display("FAIL wrap_second_addr got=%h want=0000", oa[1]);
        end
    endtask

    task automatic test_start_ignored();
        logic [AW-1:0] b = 16'h3000;
        logic [AW-1:0] s = 16'h0020;
        int n = 2 * ROWS;
        fill_random();
        drain_run(b, s, 1'b1, 30, 2, 1'b1, 1'b0, -1);
        total++;
        if (oa.size() !== n) begin bad++; $display("FAIL glitch_count got=%0d want=%0d", oa.size(), n); end
        for (int k = 0; k < oa.size() && k < n; k++) begin
            total++;
            if (oa[k] !== m_addr(k, b, s, 1) || od[k] !== m_data(k, 1)) begin
                bad++;
                $display("FAIL glitch_beat%0d addr=%h want=%h", k, oa[k], m_addr(k, b, s, 1));
            end
        end
        total++;
        if ({done_hit, done_after, busy_after} !== 3'b100) begin
            bad++;
            $display("FAIL glitch_done done=%b done_after=%b busy_after=%b want 1 0 0",
                     done_hit, done_after, busy_after);
        end
    endtask

    task automatic test_snapshot_iso();
        for (int t = 0; t < 2; t++) begin
            bit i16 = t[0];
            int n = i16 ? 2 * ROWS : ROWS;
            logic [AW-1:0] b = AW'($urandom);
            fill_random();
            drain_run(b, 16'h0080, i16, 20, 1, 1'b0, 1'b1, -1);
            total++;
            if (oa.size() !== n) begin bad++; $display("FAIL snap%0d_count got=%0d want=%0d", t, oa.size(), n); end
            for (int k = 0; k < oa.size() && k < n; k++) begin
                total++;
                if (od[k] !== m_data(k, i16)) begin
                    bad++;
                    $display("FAIL snap%0d_beat%0d data=%h want=%h", t, k, od[k], m_data(k, i16));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [AW-1:0] b = 16'h0400;
        logic [AW-1:0] s = 16'h0030;
        bit done_seen = 0;
        fill_random();
        drain_run(16'h4000, 16'h0010, 1'b0, 0, 2, 1'b0, 1'b0, 7);
        #1;
        total++;
        if ({wb_vld, wb_last, drn_busy, drn_done, wb_addr, wb_data} !== '0) begin
            bad++;
            $display("FAIL midreset_outputs vld=%b last=%b busy=%b done=%b addr=%h data=%h required all 0",
                     wb_vld, wb_last, drn_busy, drn_done, wb_addr, wb_data);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (drn_done !== 1'b0) done_seen = 1;
        end
        rst_n = 1'b1;
        @(negedge clk);
        if (drn_done !== 1'b0 || drn_busy !== 1'b0) done_seen = 1;
        total++;
        if (done_seen) begin bad++; $display("FAIL midreset_no_done saw done/busy after abandoned drain"); end
        fill_random();
        drain_run(b, s, 1'b0, 0, 1, 1'b0, 1'b0, -1);
        total++;
        if (oa.size() !== ROWS) begin bad++; $display("FAIL postreset_count got=%0d want=%0d", oa.size(), ROWS); end
        for (int k = 0; k < oa.size() && k < ROWS; k++) begin
            total++;
            if (oa[k] !== m_addr(k, b, s, 0) || od[k] !== m_data(k, 0) || ol[k] !== (k == ROWS - 1)) begin
                bad++;
                $display("FAIL postreset_beat%0d addr=%h want=%h data=%h want=%h", k, oa[k],
                         m_addr(k, b, s, 0), od[k], m_data(k, 0));
            end
        end
        total++;
        if ({done_hit, done_after} !== 2'b10) begin
            bad++; $display("FAIL postreset_done done=%b after=%b want 1 0", done_hit, done_after);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drn_start = 1'b0;
        drn_base_addr = '0;
        drn_stride = '0;
        drn_int16 = 1'b0;
        mxu_lsu_data_rdy = 1'b0;
        mxu_int8_data = '0;
        mxu_int16_data = '0;
        wb_rdy = 1'b0;
        test_reset();
        test_int8();
        test_int16();
        test_backpressure();
        test_wrap();
        test_start_ignored();
        test_snapshot_iso();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
